vera_sweep_ctrl: RTL and testbench
==================================

# vera_sweep_ctrl

Sequencer that drives the three-input combinational block `vera` (inputs x, y, z; outputs f4, f5, f6) through all eight input combinations in ascending order. At each combination it waits a programmable settle time, captures f4/f5/f6, and compares them against a caller-supplied expected truth table. It sits between a host-side start/done handshake and a single `vera` instance. It replaces open-loop stimulus with an in-system, self-checking exhaustive sweep.

## Interface
- SETTLE_CYCLES, 2, cycles from applying x/y/z to sampling f4..f6; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level; sampled in IDLE only; begins a sweep.
- abort  input  1  level; cancels a sweep in progress.
- expected  input  24  expected outputs; slice [3i+2:3i] = {f4,f5,f6} for minterm i = {x,y,z}.
- f4, f5, f6  input  1 each  outputs of `vera`.
- x, y, z  output  1 each  registered drive to `vera`; {x,y,z} = current minterm index.
- busy  output  1  high while a sweep is in progress (SETTLE or SAMPLE).
- done  output  1  one-cycle pulse when a sweep completes; no pulse on abort.
- pass  output  1  1 when the last completed sweep had no mismatches.
- mismatch_mask  output  8  bit i set when minterm i mismatched.
- captured  output  24  captured {f4,f5,f6} per minterm, same packing as expected.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. 4-bit settle counter; 3-bit minterm index idx.
- IDLE: busy=0. On start=1 and abort=0: latch expected into an internal register; set idx=0 and {x,y,z}=000; clear mismatch_mask, captured, and pass; load counter=0; go to SETTLE.
- SETTLE: increment counter each cycle. When counter reaches SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE (one cycle): write {f4,f5,f6} into captured[3*idx+:3]. Set mismatch_mask[idx] if the sample differs from the latched expected slice.
  - If idx==7, go to DONE.
  - Otherwise increment idx, update {x,y,z}=idx+1, reset counter, and go to SETTLE.
- DONE (one cycle): done=1; pass=(final mismatch_mask==0); next state IDLE.
- Results (pass, mismatch_mask, captured) are held until the next accepted start.
- abort=1 in SETTLE or SAMPLE: next state IDLE. {x,y,z}=000, busy=0, no done pulse, pass=0. Partial captured and mismatch_mask are retained.
- abort and start both high in IDLE: abort wins; start is ignored.
- start while busy is ignored; expected is not re-latched mid-sweep.
- A change of the expected input after start is accepted has no effect on the current sweep.
- The comparison for minterm 7 is folded into pass in the DONE cycle; no minterm is dropped.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE; x=y=z=0, busy=0, done=0, pass=0, mismatch_mask=0, captured=0, idx=0, counter=0.
- Reset asserted mid-sweep forces these values immediately; no done pulse.
- Edge E0 accepts start; busy is high from E0 until the edge that enters DONE.
- Each minterm occupies SETTLE_CYCLES+1 cycles. {x,y,z} is stable for the full SETTLE period before its SAMPLE edge.
- Minterm i is sampled at edge E0 + (i+1)·(SETTLE_CYCLES+1).
- done is high for exactly the one cycle following edge E0 + 8·(SETTLE_CYCLES+1). For the default SETTLE_CYCLES=2, that edge is E0+24.
- Back-to-back: start held high through DONE is accepted on the edge leaving IDLE. Minimum start-to-start spacing is 8·(SETTLE_CYCLES+1)+2 cycles.

## Test plan
- Loopback model (f4=x, f5=y, f6=z), expected=24'hFAC688, SETTLE_CYCLES=2:
  - done pulses one cycle after E0+24; pass=1.
  - mismatch_mask=8'h00; captured=24'hFAC688.
  - {x,y,z} steps 000..111, three cycles each.
- Same loopback model, expected=24'hFA4688 (minterm 5 f6 bit flipped): pass=0, mismatch_mask=8'h20, captured=24'hFAC688.
- Abort raised during minterm 3 SETTLE:
  - Next cycle: busy=0, {x,y,z}=000, no done, pass=0.
  - mismatch_mask bits 7:3 = 0.
  - A following start runs a full sweep with pass=1.
- rst_n pulsed low mid-sweep for 1 ns (asynchronous to clk): all outputs at reset values immediately; state returns to IDLE; no done.
- Protocol edge cases:
  - start re-pulsed while busy: no effect on timing.
  - start and abort high together in IDLE: sweep not started.
  - start held high continuously: two consecutive sweeps, with done pulses exactly 26 cycles apart.
- SETTLE_CYCLES=1 and 15: done lands at E0+16 and E0+128 respectively. Each sample is taken only after {x,y,z} has been stable for SETTLE_CYCLES cycles.

Source files
------------

// File: rtl/vera_sweep_ctrl.sv
// Exhaustive self-checking sweep of the three-input `vera` block: steps {x,y,z}
// through 000..111, waits SETTLE_CYCLES per minterm, captures f4..f6 and compares.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start (abort has priority); results held
// SETTLE | {x,y,z} applied, counting settle cycles for current minterm
// SAMPLE | capture {f4,f5,f6}, compare, advance or finish
// DONE   | one-cycle done pulse; pass valid
module vera_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] expected,
  input  logic        f4,
  input  logic        f5,
  input  logic        f6,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  mismatch_mask,
  output logic [23:0] captured
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [23:0] exp_q, exp_d;
  logic [23:0] cap_q, cap_d;
  logic [7:0]  mask_q, mask_d;
  logic        pass_q, pass_d;

  logic [4:0]  base;
  logic [2:0]  sample;
  logic        mism;

  assign base   = {2'b00, idx_q} * 5'd3;
  assign sample = {f4, f5, f6};
  assign mism   = (sample != exp_q[base +: 3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      exp_q   <= '0;
      cap_q   <= '0;
      mask_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      cap_q   <= cap_d;
      mask_q  <= mask_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    cap_d   = cap_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d = S_SETTLE;
          exp_d   = expected;
          idx_d   = '0;
          cnt_d   = '0;
          cap_d   = '0;
          mask_d  = '0;
          pass_d  = 1'b0;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          pass_d  = 1'b0;
        end else begin
          cap_d[base +: 3] = sample;
          if (mism) mask_d[idx_q] = 1'b1;
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            // Minterm 7's compare is folded in here so pass is valid alongside done.
            state_d = S_DONE;
            pass_d  = (mask_q == 8'h00) && !mism;
          end else begin
            state_d = S_SETTLE;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign {x, y, z}     = idx_q;
  assign busy          = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign mismatch_mask = mask_q;
  assign captured      = cap_q;

endmodule

// File: tb/tb_vera_sweep_ctrl.sv
// Scoreboard bench for vera_sweep_ctrl with a loopback `vera` model (f4=x, f5=y, f6=z),
// exercised at SETTLE_CYCLES of 2, 1 and 15.
`timescale 1ns/1ps
module tb_vera_sweep_ctrl;

  typedef struct packed {
    logic        pass;
    logic [7:0]  mask;
    logic [23:0] cap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_v [3];
  logic        abort_v [3];
  logic [23:0] exp_v   [3];
  logic        x_v     [3];
  logic        y_v     [3];
  logic        z_v     [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        pass_v  [3];
  logic [7:0]  mask_v  [3];
  logic [23:0] cap_v   [3];

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  vera_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]), .expected(exp_v[0]),
    .f4(x_v[0]), .f5(y_v[0]), .f6(z_v[0]), .x(x_v[0]), .y(y_v[0]), .z(z_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .mismatch_mask(mask_v[0]), .captured(cap_v[0]));

  vera_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]), .expected(exp_v[1]),
    .f4(x_v[1]), .f5(y_v[1]), .f6(z_v[1]), .x(x_v[1]), .y(y_v[1]), .z(z_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .mismatch_mask(mask_v[1]), .captured(cap_v[1]));

  vera_sweep_ctrl #(.SETTLE_CYCLES(15)) u_dut15 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]), .expected(exp_v[2]),
    .f4(x_v[2]), .f5(y_v[2]), .f6(z_v[2]), .x(x_v[2]), .y(y_v[2]), .z(z_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .mismatch_mask(mask_v[2]), .captured(cap_v[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int settle_of(input int sel);
    case (sel)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // Loopback model: minterm i always reads back as i.
  function automatic exp_t model(input logic [23:0] e);
    exp_t r;
    logic [2:0] sl;
    r.cap  = '0;
    r.mask = '0;
    for (int i = 0; i < 8; i++) begin
      r.cap[3*i +: 3] = 3'(i);
      sl = e[3*i +: 3];
      if (sl != 3'(i)) r.mask[i] = 1'b1;
    end
    r.pass = (r.mask == 8'h00);
    return r;
  endfunction

  task automatic pop_cmp(input int sel, input string tag);
    exp_t ex;
    if (sb_q.size() > 0) begin
      ex = sb_q.pop_front();
      chk({tag, "_pass"}, pass_v[sel], ex.pass);
      chk({tag, "_mask"}, mask_v[sel], ex.mask);
      chk({tag, "_cap"},  cap_v[sel],  ex.cap);
    end
  endtask

  task automatic run_sweep(input int sel, input logic [23:0] e, input bit repulse);
    int per, total;
    per   = settle_of(sel) + 1;
    total = 8 * per;
    @(negedge clk);
    exp_v[sel]   = e;
    start_v[sel] = 1'b1;
    sb_q.push_back(model(e));
    for (int k = 0; k <= total; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start_v[sel] = 1'b0;
        exp_v[sel]   = ~e;
      end
      if (repulse && k == 5) start_v[sel] = 1'b1;
      if (repulse && k == 6) start_v[sel] = 1'b0;
      if (k < total) begin
        chk("xyz_step", {x_v[sel], y_v[sel], z_v[sel]}, k / per);
        chk("busy_sweep", busy_v[sel], 1'b1);
        chk("done_early", done_v[sel], 1'b0);
      end else begin
        chk("done_latency", done_v[sel], 1'b1);
        chk("busy_at_done", busy_v[sel], 1'b0);
        pop_cmp(sel, "sweep");
      end
    end
    @(negedge clk);
    chk("done_width", done_v[sel], 1'b0);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done_v[0]) n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, first, nd;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      exp_v[i]   = '0;
    end
    #1;
    chk("rst_xyz",  {x_v[0], y_v[0], z_v[0]}, 3'b000);
    chk("rst_busy", busy_v[0], 1'b0);
    chk("rst_done", done_v[0], 1'b0);
    chk("rst_pass", pass_v[0], 1'b0);
    chk("rst_mask", mask_v[0], 8'h00);
    chk("rst_cap",  cap_v[0],  24'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Loopback with matching table, with start re-pulsed mid-sweep
    run_sweep(0, 24'hFAC688, 1'b1);
    // Minterm 5 f6 flipped
    run_sweep(0, 24'hFA4688, 1'b0);
    chk("flip_mask", mask_v[0], 8'h20);

    // Abort during minterm 3 SETTLE
    @(negedge clk);
    exp_v[0] = 24'hFAC688; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort_busy", busy_v[0], 1'b0);
    chk("abort_xyz",  {x_v[0], y_v[0], z_v[0]}, 3'b000);
    chk("abort_done", done_v[0], 1'b0);
    chk("abort_pass", pass_v[0], 1'b0);
    chk("abort_mask_hi", mask_v[0] & 8'hF8, 8'h00);
    chk("abort_cap_partial", cap_v[0], 24'h000088);
    count_done(30, n);
    chk("abort_no_done", n, 0);
    run_sweep(0, 24'hFAC688, 1'b0);

    // Asynchronous reset mid-sweep
    @(negedge clk);
    exp_v[0] = 24'h000000; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #0.5;
    chk("arst_busy", busy_v[0], 1'b0);
    chk("arst_xyz",  {x_v[0], y_v[0], z_v[0]}, 3'b000);
    chk("arst_mask", mask_v[0], 8'h00);
    chk("arst_cap",  cap_v[0],  24'h0);
    chk("arst_pass", pass_v[0], 1'b0);
    #0.5;
    rst_n = 1'b1;
    count_done(30, n);
    chk("arst_no_done", n, 0);
    chk("arst_idle", busy_v[0], 1'b0);

    // start and abort together in IDLE
    @(negedge clk);
    exp_v[0] = 24'hFAC688; start_v[0] = 1'b1; abort_v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("start_abort_busy", busy_v[0], 1'b0);
    end
    start_v[0] = 1'b0; abort_v[0] = 1'b0;

    // start held high: back-to-back sweeps 26 cycles apart
    @(negedge clk);
    exp_v[0] = 24'hFAC688; start_v[0] = 1'b1;
    sb_q.push_back(model(24'hFAC688));
    sb_q.push_back(model(24'hFAC688));
    first = 0; nd = 0;
    for (int c = 0; c < 100 && nd < 2; c++) begin
      @(negedge clk);
      if (done_v[0]) begin
        pop_cmp(0, "b2b");
        if (nd == 0) first = c;
        else chk("b2b_spacing", c - first, 26);
        if (nd == 0) chk("b2b_first_latency", c, 24);
        nd++;
        if (nd == 2) start_v[0] = 1'b0;
      end
    end
    chk("b2b_count", nd, 2);
    repeat (3) @(negedge clk);
    chk("b2b_stopped", busy_v[0], 1'b0);

    // Settle-time extremes
    run_sweep(1, 24'hFAC688, 1'b0);
    run_sweep(2, 24'hFAC688, 1'b0);
    run_sweep(2, 24'hFA4688, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
